pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined logarithmic barrel shifter for the EX stage. Supports SLL, SRL, SRA and, optionally, ROR.
- Produces the result and C/V/N/Z flags with fixed latency.
- Carries a tag through the pipeline so the result can be matched to its destination register.
- Valid/ready handshake on input and output; the pipeline stalls as a whole.

Parameters:
- WIDTH, 32, operand width; power of 2, ≥8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.
- PIPE_STAGES, 2, register stages from input to output; 1..SHW.
- TAG_W, 5, width of the tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_data  in  WIDTH  operand T
- in_shamt  in  SHW  shift amount
- in_mode  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROR (or reserved)
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  WIDTH  result Y
- out_tag  out  TAG_W  tag of the result
- out_flags  out  4  {C,V,N,Z}

Behaviour:
- Reset (async assert, sync release): every stage valid bit = 0. out_valid=0, out_data=0, out_tag=0, out_flags=0.
- Global advance: en = !out_valid | out_ready. in_ready = en (combinational).
- When en=1, all stage registers load from the previous stage. Valid bits shift along with the data.
- When en=0, all stages hold.
- Bubbles are not compressed.
- Latency: an op accepted at edge k appears on out_* after edge k+PIPE_STAGES-1, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 op/cycle with out_ready held high.
- Levels: SHW log levels, level i shifts by 2^i when shamt[i]=1.
- Level i sits in register stage floor(i*PIPE_STAGES/SHW). The final stage output is registered.
- shamt, mode and tag travel with the data.
- Shift semantics per mode:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the original T[WIDTH-1].
  - ROR: bits wrap MSB-ward.
- shamt=0: Y=T in all modes.
- shamt=WIDTH-1 under SRA: Y = all copies of the sign bit.
- C, the last bit shifted out:
  - SLL: T[WIDTH-shamt].
  - SRL/SRA: T[shamt-1].
  - ROR: Y[WIDTH-1].
  - shamt=0: C=0.
- V=0 always. N=Y[WIDTH-1]. Z=(Y==0). Flags are registered together with Y.
- Output stability: while out_valid & !out_ready, out_data, out_tag and out_flags must hold.
- Simultaneous in/out: with out_valid & out_ready & in_valid, the output is consumed and the new op is accepted in the same cycle.
- Reset mid-operation: all in-flight ops are discarded and no result is emitted after release.

Optional Feature:
- Macro: BSHIFT_ROTATE_EN.
- Defined: mode 11 = ROR as described above.
- Undefined: mode 11 is reserved and behaves exactly as SRL, including flags. No rotate muxes are synthesised.

Test Plan:
- Case 1 (WIDTH=32, PIPE_STAGES=2):
  - Stimulus: SRA, T=0x80000010, shamt=4, out_ready=1.
  - Response: after 2 edges, out_data=0xF8000001, C=0, N=1, Z=0, V=0, tag echoed.
- Case 2:
  - Stimulus: SLL, T=0xC0000001, shamt=1.
  - Response: out_data=0x80000002, C=1, N=1, Z=0.
- Case 3:
  - Stimulus: SRL, T=0x00000001, shamt=1.
  - Response: out_data=0, C=1, Z=1, N=0.
  - Stimulus: SRA, T=0x80000000, shamt=31.
  - Response: out_data=0xFFFFFFFF, C=0, N=1.
- Case 4 (back-pressure):
  - Stimulus: stream 4 ops, hold out_ready=0 for 3 cycles mid-stream.
  - Response: in_ready=0 throughout the stall, out_* stable, all 4 results delivered in order with correct tags, no loss or duplication.
- Case 5 (BSHIFT_ROTATE_EN):
  - Defined: mode=11, T=0x00000001, shamt=1 → out_data=0x80000000, C=1.
  - Undefined, same stimulus → out_data=0x00000000, C=1, Z=1.
- Case 6 (reset mid-stream):
  - Stimulus: assert reset_n=0 asynchronously with 2 ops in flight.
  - Response: out_valid drops to 0 immediately and all out_* are 0. After release, no stale result appears and the next op has normal latency.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log barrel shifter for EX: SLL/SRL/SRA (+ROR when BSHIFT_ROTATE_EN),
// fixed latency, tag passthrough, {C,V,N,Z} flags, whole-pipe stall handshake.
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 32,
    parameter int SHW         = $clog2(WIDTH),
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);

    localparam int PS = PIPE_STAGES;

    logic                         en;
    logic                         v_q  [PS];
    logic [WIDTH-1:0]             d_q  [PS];
    logic [SHW-1:0]               sa_q [PS];
    logic [1:0]                   md_q [PS];
    logic [TAG_W-1:0]             tg_q [PS];
    logic                         c_q  [PS];
    logic [3:0]                   fl_q;
    logic [PS-1:0][WIDTH-1:0]     y_c;
    logic                         c_in;
    logic                         c_last;
    logic [SHW-1:0]               nsh;
    logic [SHW-1:0]               sm1;

    function automatic logic [WIDTH-1:0] lvl(
        input logic [WIDTH-1:0] v,
        input int               k,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = v << k;
            2'b10:   r = $signed(v) >>> k;
`ifdef BSHIFT_ROTATE_EN
            2'b11:   r = (v >> k) | (v << (WIDTH - k));
`endif
            default: r = v >> k;
        endcase
        return r;
    endfunction

    assign en        = !v_q[PS-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[PS-1];
    assign out_data  = d_q[PS-1];
    assign out_tag   = tg_q[PS-1];
    assign out_flags = fl_q;

    // Carry is resolved from the original operand at entry; for ROR the
    // wrapped MSB Y[W-1] is T[shamt-1], the same bit SRL/SRA shift out.
    always_comb begin
        nsh  = '0 - in_shamt;
        sm1  = in_shamt - SHW'(1);
        c_in = 1'b0;
        if (in_shamt != '0) begin
            c_in = (in_mode == 2'b00) ? in_data[nsh] : in_data[sm1];
        end
    end

    for (genvar s = 0; s < PS; s++) begin : g_st
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [SHW-1:0]   sa;
        logic [1:0]       md;

        if (s == 0) begin : g_in
            assign x  = in_data;
            assign sa = in_shamt;
            assign md = in_mode;
        end else begin : g_mid
            assign x  = d_q[s-1];
            assign sa = sa_q[s-1];
            assign md = md_q[s-1];
        end

        always_comb begin
            y = x;
            for (int i = 0; i < SHW; i++) begin
                if (((i * PS) / SHW) == s && sa[i]) begin
                    y = lvl(y, 1 << i, md);
                end
            end
        end

        assign y_c[s] = y;
    end

    if (PS == 1) begin : g_c1
        assign c_last = c_in;
    end else begin : g_cn
        assign c_last = c_q[PS-2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < PS; s++) begin
                v_q[s]  <= 1'b0;
                d_q[s]  <= '0;
                sa_q[s] <= '0;
                md_q[s] <= '0;
                tg_q[s] <= '0;
                c_q[s]  <= 1'b0;
            end
            fl_q <= '0;
        end else if (en) begin
            v_q[0]  <= in_valid;
            d_q[0]  <= y_c[0];
            sa_q[0] <= in_shamt;
            md_q[0] <= in_mode;
            tg_q[0] <= in_tag;
            c_q[0]  <= c_in;
            for (int s = 1; s < PS; s++) begin
                v_q[s]  <= v_q[s-1];
                d_q[s]  <= y_c[s];
                sa_q[s] <= sa_q[s-1];
                md_q[s] <= md_q[s-1];
                tg_q[s] <= tg_q[s-1];
                c_q[s]  <= c_q[s-1];
            end
            fl_q <= {c_last, 1'b0, y_c[PS-1][WIDTH-1], ~|y_c[PS-1]};
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=32, PIPE_STAGES=2).
module tb_pipelined_barrel_shifter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [3:0]  out_flags;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(
        .WIDTH(32), .PIPE_STAGES(2), .TAG_W(5)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .out_flags(out_flags)
    );

    task automatic send(input logic [1:0] m, input logic [31:0] t,
                        input logic [4:0] sa, input logic [4:0] tg);
        @(negedge clk);
        in_mode  = m;
        in_data  = t;
        in_shamt = sa;
        in_tag   = tg;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 0; out_ready = 1;
        in_data = 0; in_shamt = 0; in_mode = 0; in_tag = 0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 ||
            out_flags !== 4'h0)
            $display("FAIL reset_outs: got v=%b d=%h t=%h f=%b want all 0",
                     out_valid, out_data, out_tag, out_flags);
        else passed++;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_shifts();
        logic [1:0]  m [10] = '{2, 0, 1, 2, 0, 2, 0, 1, 2, 1};
        logic [31:0] t [10] = '{32'h80000010, 32'hC0000001, 32'h00000001,
                                32'h80000000, 32'h12345678, 32'h80000000,
                                32'h00000003, 32'hF0000000, 32'h7FFFFFFF,
                                32'h80000000};
        logic [4:0]  sa[10] = '{4, 1, 1, 31, 0, 0, 31, 28, 31, 31};
        logic [31:0] y [10] = '{32'hF8000001, 32'h80000002, 32'h00000000,
                                32'hFFFFFFFF, 32'h12345678, 32'h80000000,
                                32'h80000000, 32'h0000000F, 32'h00000000,
                                32'h00000001};
        logic [3:0]  fl[10] = '{4'b0010, 4'b1010, 4'b1001, 4'b0010, 4'b0000,
                                4'b0010, 4'b1010, 4'b0000, 4'b1001, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            send(m[i], t[i], sa[i], 5'(i + 3));
            checks++;
            if (out_valid !== 1'b1 || out_data !== y[i])
                $display("FAIL shift_data[%0d]: got v=%b %h want v=1 %h",
                         i, out_valid, out_data, y[i]);
            else passed++;
            checks++;
            if (out_flags !== fl[i])
                $display("FAIL shift_flags[%0d]: got %b want %b",
                         i, out_flags, fl[i]);
            else passed++;
            checks++;
            if (out_tag !== 5'(i + 3))
                $display("FAIL shift_tag[%0d]: got %h want %h",
                         i, out_tag, 5'(i + 3));
            else passed++;
        end
    endtask

    task automatic test_rotate();
`ifdef BSHIFT_ROTATE_EN
        logic [31:0] y0 = 32'h80000000;
        logic [3:0]  f0 = 4'b1010;
        logic [31:0] y1 = 32'h78123456;
`else
        logic [31:0] y0 = 32'h00000000;
        logic [3:0]  f0 = 4'b1001;
        logic [31:0] y1 = 32'h00123456;
`endif
        send(2'b11, 32'h00000001, 5'd1, 5'h1E);
        checks++;
        if (out_valid !== 1'b1 || out_data !== y0 || out_flags !== f0)
            $display("FAIL mode11_a: got v=%b %h f=%b want v=1 %h f=%b",
                     out_valid, out_data, out_flags, y0, f0);
        else passed++;
        send(2'b11, 32'h12345678, 5'd8, 5'h1F);
        checks++;
        if (out_data !== y1 || out_flags !== 4'b0000 || out_tag !== 5'h1F)
            $display("FAIL mode11_b: got %h f=%b t=%h want %h f=0000 t=1f",
                     out_data, out_flags, out_tag, y1);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  m [4] = '{0, 0, 1, 2};
        logic [31:0] t [4] = '{32'h1, 32'h1, 32'h100, 32'h80000000};
        logic [4:0]  sa[4] = '{1, 2, 4, 1};
        logic [31:0] y [4] = '{32'h2, 32'h4, 32'h10, 32'hC0000000};
        int          idx = 0;
        int          rcv = 0;
        logic [31:0] hd;
        logic [4:0]  ht;
        logic [3:0]  hf;
        logic        acc;
        logic        del;
        for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                in_mode  = m[idx];
                in_data  = t[idx];
                in_shamt = sa[idx];
                in_tag   = 5'(idx + 1);
            end
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1)
                    $display("FAIL stall_ready[%0d]: got rdy=%b v=%b want 0/1",
                             cyc, in_ready, out_valid);
                else passed++;
                if (cyc == 3) begin
                    hd = out_data; ht = out_tag; hf = out_flags;
                end else begin
                    checks++;
                    if (out_data !== hd || out_tag !== ht || out_flags !== hf)
                        $display("FAIL stall_hold[%0d]: got %h/%h/%b want %h/%h/%b",
                                 cyc, out_data, out_tag, out_flags, hd, ht, hf);
                    else passed++;
                end
            end
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                checks++;
                if (out_data !== y[rcv] || out_tag !== 5'(rcv + 1))
                    $display("FAIL stream[%0d]: got %h tag %h want %h tag %h",
                             rcv, out_data, out_tag, y[rcv], 5'(rcv + 1));
                else passed++;
                rcv++;
            end
            if (acc) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv != 4)
            $display("FAIL stream_count: got %0d want 4", rcv);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL stream_dup: got out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b0;
        @(negedge clk);
        in_mode = 2'b00; in_data = 32'h5; in_shamt = 5'd1;
        in_tag = 5'h11; in_valid = 1'b1;
        @(negedge clk);
        in_tag = 5'h12; in_data = 32'h6;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 ||
            out_flags !== 4'h0)
            $display("FAIL async_reset: got v=%b d=%h t=%h f=%b want all 0",
                     out_valid, out_data, out_tag, out_flags);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0)
            $display("FAIL reset_stale: got %0d valid cycles want 0", stale);
        else passed++;
        send(2'b01, 32'h00000100, 5'd8, 5'h15);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1 || out_tag !== 5'h15 ||
            out_flags !== 4'b0000)
            $display("FAIL reset_next_op: got v=%b %h t=%h f=%b want 1 1 15 0000",
                     out_valid, out_data, out_tag, out_flags);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_rotate();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
